// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating bubble counter for performance debug.
module id_ex_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    input  logic                id_RegWrite,
    input  logic                id_MemRead,
    input  logic                id_MemWrite,
    input  logic                id_MemtoReg,
    input  logic                id_Branch,
    input  logic                id_ALUSrc,
    input  logic                id_RegDst,
    input  logic                id_uses_rt,
    input  logic [2:0]          id_ALUop,
    input  logic [5:0]          id_funct,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic [4:0]          id_rd,
    input  logic [DATA_W-1:0]   id_rs_data,
    input  logic [DATA_W-1:0]   id_rt_data,
    input  logic [DATA_W-1:0]   id_imm,
    output logic                ex_valid,
    output logic                ex_RegWrite,
    output logic                ex_MemRead,
    output logic                ex_MemWrite,
    output logic                ex_MemtoReg,
    output logic                ex_Branch,
    output logic                ex_ALUSrc,
    output logic                ex_RegDst,
    output logic                ex_uses_rt,
    output logic [2:0]          ex_ALUop,
    output logic [5:0]          ex_funct,
    output logic [4:0]          ex_rs,
    output logic [4:0]          ex_rt,
    output logic [4:0]          ex_rd,
    output logic [DATA_W-1:0]   ex_rs_data,
    output logic [DATA_W-1:0]   ex_rt_data,
    output logic [DATA_W-1:0]   ex_imm,
    output logic                stall_out,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned FUNCT_W = 6;

    logic hazard_c;
    logic bubble_c;
    logic rt_match_c;

    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        rt_match_c = 1'b0;
        hazard_c   = 1'b0;
        if ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) begin
            rt_match_c = 1'b1;
        end
        if (!rst && !flush && id_valid && ex_valid && ex_MemRead &&
            (ex_rt != REG_W'(0)) && rt_match_c) begin
            hazard_c = 1'b1;
        end
    end

    assign stall_out = hazard_c;
    // A flush coinciding with a hazard is still a single bubble.
    assign bubble_c  = flush | hazard_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegDst   <= 1'b0;
            ex_uses_rt  <= 1'b0;
            ex_ALUop    <= ALUOP_W'(0);
            ex_funct    <= FUNCT_W'(0);
            ex_rs       <= REG_W'(0);
            ex_rt       <= REG_W'(0);
            ex_rd       <= REG_W'(0);
            ex_rs_data  <= DATA_W'(0);
            ex_rt_data  <= DATA_W'(0);
            ex_imm      <= DATA_W'(0);
            bubble_cnt  <= CNT_W'(0);
        end else begin
            ex_ALUSrc   <= id_ALUSrc;
            ex_RegDst   <= id_RegDst;
            ex_uses_rt  <= id_uses_rt;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            if (bubble_c) begin
                // Bubble: ALUop add with every side effect disabled.
                ex_valid    <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_ALUop    <= ALUOP_W'(0);
                ex_funct    <= FUNCT_W'(0);
                if (bubble_cnt != {CNT_W{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                ex_valid    <= id_valid;
                ex_RegWrite <= id_RegWrite;
                ex_MemRead  <= id_MemRead;
                ex_MemWrite <= id_MemWrite;
                ex_MemtoReg <= id_MemtoReg;
                ex_Branch   <= id_Branch;
                ex_ALUop    <= id_ALUop;
                ex_funct    <= id_funct;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: stimulus queues hand-derived expectations,
// a negedge monitor pops and compares them.
module tb_id_ex_register;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic        valid;
        logic        rw, mr, mw, m2r, br, asrc, rdst, urt;
        logic [2:0]  alu;
        logic [5:0]  fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
    } ins_t;

    typedef enum logic [1:0] {K_RESET, K_LOAD, K_BUBBLE} kind_t;

    typedef struct {
        logic             stall;
        logic [CNT_W-1:0] cnt;
        kind_t            kind;
        ins_t             src;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush;
    logic id_valid, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_Branch;
    logic id_ALUSrc, id_RegDst, id_uses_rt;
    logic [2:0] id_ALUop;
    logic [5:0] id_funct;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch;
    logic ex_ALUSrc, ex_RegDst, ex_uses_rt;
    logic [2:0] ex_ALUop;
    logic [5:0] ex_funct;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic stall_out;
    logic [CNT_W-1:0] bubble_cnt;

    exp_t  q[$];
    string qn[$];
    exp_t  mon_e;
    string cur;
    int    vectors = 0;
    int    miscompares = 0;
    kind_t prev_kind = K_RESET;
    ins_t  prev_ins = '0;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
        .id_RegDst(id_RegDst), .id_uses_rt(id_uses_rt), .id_ALUop(id_ALUop),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_uses_rt(ex_uses_rt),
        .ex_ALUop(ex_ALUop), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
    );

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd,
                                   input logic [31:0] rsd, rtd);
        ins_t i = '0;
        i.valid = 1'b1; i.rw = 1'b1; i.rdst = 1'b1; i.urt = 1'b1; i.alu = 3'b010;
        i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd; i.rsd = rsd; i.rtd = rtd;
        return i;
    endfunction

    function automatic ins_t lw(input logic [4:0] rs, rt, input logic [31:0] imm);
        ins_t i = '0;
        i.valid = 1'b1; i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.asrc = 1'b1;
        i.rs = rs; i.rt = rt; i.imm = imm; i.fn = imm[5:0]; i.rsd = 32'h1000;
        return i;
    endfunction

    function automatic ins_t sw(input logic [4:0] rs, rt, input logic [31:0] imm);
        ins_t i = '0;
        i.valid = 1'b1; i.mw = 1'b1; i.asrc = 1'b1; i.urt = 1'b1;
        i.rs = rs; i.rt = rt; i.imm = imm; i.fn = imm[5:0]; i.rtd = 32'hCAFE;
        return i;
    endfunction

    function automatic ins_t addi(input logic [4:0] rs, rt, input logic [31:0] imm);
        ins_t i = '0;
        i.valid = 1'b1; i.rw = 1'b1; i.asrc = 1'b1;
        i.rs = rs; i.rt = rt; i.imm = imm; i.fn = imm[5:0]; i.rsd = 32'd3;
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i = {$urandom, $urandom, $urandom, $urandom};
        return i;
    endfunction

    task automatic apply(input ins_t i, input logic fl, input logic r);
        rst = r; flush = fl;
        id_valid = i.valid; id_RegWrite = i.rw; id_MemRead = i.mr; id_MemWrite = i.mw;
        id_MemtoReg = i.m2r; id_Branch = i.br; id_ALUSrc = i.asrc; id_RegDst = i.rdst;
        id_uses_rt = i.urt; id_ALUop = i.alu; id_funct = i.fn; id_rs = i.rs;
        id_rt = i.rt; id_rd = i.rd; id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
    endtask

    // st/cnt: expected at this cycle; nxt: what the coming edge must do.
    task automatic step(input string nm, input ins_t i, input logic fl, input logic r,
                        input logic st, input int cnt, input kind_t nxt);
        exp_t e;
        @(posedge clk);
        #1;
        apply(i, fl, r);
        e.stall = st; e.cnt = CNT_W'(cnt); e.kind = prev_kind; e.src = prev_ins;
        q.push_back(e);
        qn.push_back(nm);
        prev_kind = nxt;
        prev_ins = i;
    endtask

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %0h expected %0h", cur, what, act, exp);
        end
    endtask

    task automatic chk_ctl(input ins_t s);
        chk("ex_valid", 32'(ex_valid), 32'(s.valid));
        chk("ex_RegWrite", 32'(ex_RegWrite), 32'(s.rw));
        chk("ex_MemRead", 32'(ex_MemRead), 32'(s.mr));
        chk("ex_MemWrite", 32'(ex_MemWrite), 32'(s.mw));
        chk("ex_MemtoReg", 32'(ex_MemtoReg), 32'(s.m2r));
        chk("ex_Branch", 32'(ex_Branch), 32'(s.br));
        chk("ex_ALUop", 32'(ex_ALUop), 32'(s.alu));
        chk("ex_funct", 32'(ex_funct), 32'(s.fn));
    endtask

    task automatic chk_full(input ins_t s);
        chk_ctl(s);
        chk("ex_ALUSrc", 32'(ex_ALUSrc), 32'(s.asrc));
        chk("ex_RegDst", 32'(ex_RegDst), 32'(s.rdst));
        chk("ex_uses_rt", 32'(ex_uses_rt), 32'(s.urt));
        chk("ex_rs", 32'(ex_rs), 32'(s.rs));
        chk("ex_rt", 32'(ex_rt), 32'(s.rt));
        chk("ex_rd", 32'(ex_rd), 32'(s.rd));
        chk("ex_rs_data", ex_rs_data, s.rsd);
        chk("ex_rt_data", ex_rt_data, s.rtd);
        chk("ex_imm", ex_imm, s.imm);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            cur = qn.pop_front();
            chk("stall_out", 32'(stall_out), 32'(mon_e.stall));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(mon_e.cnt));
            case (mon_e.kind)
                K_RESET: chk_full('0);
                K_LOAD:  chk_full(mon_e.src);
                default: chk_ctl('0);
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t add_i, sub_i;
        int wait_cyc;
        add_i = rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        sub_i = rtype(6'h22, 5'd4, 5'd1, 5'd5, 32'd11, 32'd5);
        apply(rnd(), 1'b0, 1'b1);

        step("rst1", rnd(), 1'b0, 1'b1, 1'b0, 0, K_RESET);
        step("rst2", rnd(), 1'b0, 1'b1, 1'b0, 0, K_RESET);
        step("add", add_i, 1'b0, 1'b0, 1'b0, 0, K_LOAD);
        step("add_ex", nop(), 1'b0, 1'b0, 1'b0, 0, K_LOAD);
        // load-use: lw r4 then sub r5,r4,r1
        step("lw4", lw(5'd1, 5'd4, 32'd8), 1'b0, 1'b0, 1'b0, 0, K_LOAD);
        step("sub_stall", sub_i, 1'b0, 1'b0, 1'b1, 0, K_BUBBLE);
        step("sub_held", sub_i, 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        step("sub_ex", nop(), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        // lw to r0 never stalls
        step("lw0", lw(5'd1, 5'd0, 32'd4), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        step("use_r0", rtype(6'h20, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        // rt match ignored when ID does not read rt
        step("lw4b", lw(5'd2, 5'd4, 32'd12), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        step("addi", addi(5'd7, 5'd4, 32'd9), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        // dependent lw pair, then sw depending on rt
        step("lwA", lw(5'd2, 5'd8, 32'd0), 1'b0, 1'b0, 1'b0, 1, K_LOAD);
        step("lwB_stall", lw(5'd8, 5'd9, 32'd4), 1'b0, 1'b0, 1'b1, 1, K_BUBBLE);
        step("lwB_held", lw(5'd8, 5'd9, 32'd4), 1'b0, 1'b0, 1'b0, 2, K_LOAD);
        step("sw_stall", sw(5'd3, 5'd9, 32'd16), 1'b0, 1'b0, 1'b1, 2, K_BUBBLE);
        step("sw_held", sw(5'd3, 5'd9, 32'd16), 1'b0, 1'b0, 1'b0, 3, K_LOAD);
        // flush with concurrent hazard counts once
        step("lwC", lw(5'd1, 5'd10, 32'd0), 1'b0, 1'b0, 1'b0, 3, K_LOAD);
        step("flush_haz", rtype(6'h20, 5'd10, 5'd1, 5'd11, 32'd1, 32'd2), 1'b1, 1'b0, 1'b0, 3, K_BUBBLE);
        step("after_fl", nop(), 1'b0, 1'b0, 1'b0, 4, K_LOAD);
        // saturation
        for (int k = 0; k < 20; k++) begin
            step("sat", add_i, 1'b1, 1'b0, 1'b0, ((4 + k) > 15) ? 15 : (4 + k), K_BUBBLE);
        end
        step("sat_rst", add_i, 1'b0, 1'b1, 1'b0, 15, K_RESET);
        step("post_rst", nop(), 1'b0, 1'b0, 1'b0, 0, K_LOAD);
        // reset while a hazard is present
        step("lwD", lw(5'd1, 5'd4, 32'd0), 1'b0, 1'b0, 1'b0, 0, K_LOAD);
        step("rst_haz", sub_i, 1'b0, 1'b1, 1'b0, 0, K_RESET);
        step("rst_done", nop(), 1'b0, 1'b0, 1'b0, 0, K_LOAD);

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
